// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel timing from an external active-low hs/vs
// pair. It checks line/frame lengths and sync widths against the configured
// mode, declares lock after a run of clean frames, and then regenerates
// disp/x_pos/y_pos one clock behind the source.
module vga_sync_decoder #(
  parameter int H_SYNC      = 112,
  parameter int H_BACK      = 248,
  parameter int H_DISP      = 1280,
  parameter int H_FRONT     = 48,
  parameter int V_SYNC      = 3,
  parameter int V_BACK      = 38,
  parameter int V_DISP      = 1024,
  parameter int V_FRONT     = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vga_hs,
  input  logic                       vga_vs,
  output logic                       locked,
  output logic                       disp,
  output logic [$clog2(H_DISP)-1:0]  x_pos,
  output logic [$clog2(V_DISP)-1:0]  y_pos,
  output logic                       frame_start,
  output logic                       sync_err
);

  localparam int H_LIMIT = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_LIMIT = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HW      = $clog2(H_LIMIT);
  localparam int VW      = $clog2(V_LIMIT);
  localparam int XW      = $clog2(H_DISP);
  localparam int YW      = $clog2(V_DISP);
  localparam int GW      = $clog2(LOCK_FRAMES + 1);

  localparam logic [HW-1:0] H_MAX       = HW'(H_LIMIT - 1);
  localparam logic [HW-1:0] H_SYNC_LAST = HW'(H_SYNC - 1);
  localparam logic [HW-1:0] H_ACT_START = HW'(H_SYNC + H_BACK);
  localparam logic [HW:0]   H_ACT_END   = (HW+1)'(H_SYNC + H_BACK + H_DISP);
  localparam logic [VW-1:0] V_MAX       = VW'(V_LIMIT - 1);
  localparam logic [VW-1:0] V_SYNC_LAST = VW'(V_SYNC - 1);
  localparam logic [VW-1:0] V_ACT_START = VW'(V_SYNC + V_BACK);
  localparam logic [VW:0]   V_ACT_END   = (VW+1)'(V_SYNC + V_BACK + V_DISP);
  localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic          hs_prev_q, hs_prev_d;
  logic          vs_prev_q, vs_prev_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          locked_q, locked_d;
  logic          disp_q, disp_d;
  logic [XW-1:0] x_pos_q, x_pos_d;
  logic [YW-1:0] y_pos_q, y_pos_d;
  logic          frame_start_q, frame_start_d;
  logic          sync_err_q, sync_err_d;

  logic hs_fall, hs_rise, vs_fall, vs_rise;
  logic h_wrap, v_wrap, viol;

  // Sync edge detection against the previous sample.
  always_comb begin
    hs_prev_d = vga_hs;
    vs_prev_d = vga_vs;
    hs_fall   = hs_prev_q & ~vga_hs;
    hs_rise   = ~hs_prev_q & vga_hs;
    vs_fall   = vs_prev_q & ~vga_vs;
    vs_rise   = ~vs_prev_q & vga_vs;
  end

  // Line/frame counters; running off the end means a sync pulse went missing.
  always_comb begin
    h_wrap  = 1'b0;
    v_wrap  = 1'b0;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (hs_fall) begin
      h_cnt_d = '0;
    end else if (h_cnt_q == H_MAX) begin
      h_cnt_d = '0;
      h_wrap  = 1'b1;
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
    if (vs_fall) begin
      v_cnt_d = '0;
    end else if (hs_fall) begin
      if (v_cnt_q == V_MAX) begin
        v_cnt_d = '0;
        v_wrap  = 1'b1;
      end else begin
        v_cnt_d = v_cnt_q + VW'(1);
      end
    end
  end

  // Timing checks on pre-update counts, then the HUNT/CHECK/LOCKED machine.
  always_comb begin
    viol = h_wrap | v_wrap;
    if (hs_fall && (h_cnt_q != H_MAX))       viol = 1'b1;
    if (hs_rise && (h_cnt_q != H_SYNC_LAST)) viol = 1'b1;
    if (vs_fall && ((v_cnt_q != V_MAX) || !hs_fall)) viol = 1'b1;
    if (vs_rise && (v_cnt_q != V_SYNC_LAST)) viol = 1'b1;

    state_d    = state_q;
    good_d     = good_q;
    sync_err_d = 1'b0;
    case (state_q)
      HUNT: begin
        if (vs_fall) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (viol) begin
          state_d    = HUNT;
          good_d     = '0;
          sync_err_d = 1'b1;
        end else if (vs_fall) begin
          good_d = good_q + GW'(1);
          if (good_d == GOOD_TARGET) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (viol) begin
          state_d    = HUNT;
          good_d     = '0;
          sync_err_d = 1'b1;
        end
      end
      default: begin
        state_d = HUNT;
        good_d  = '0;
      end
    endcase
  end

  // Regenerated video outputs, computed from post-update counts.
  always_comb begin
    locked_d      = (state_d == LOCKED);
    frame_start_d = vs_fall;
    disp_d        = locked_d
                    && (h_cnt_d >= H_ACT_START) && ({1'b0, h_cnt_d} < H_ACT_END)
                    && (v_cnt_d >= V_ACT_START) && ({1'b0, v_cnt_d} < V_ACT_END);
    x_pos_d       = '0;
    y_pos_d       = '0;
    if (disp_d) begin
      x_pos_d = XW'(h_cnt_d - H_ACT_START);
      y_pos_d = YW'(v_cnt_d - V_ACT_START);
    end
  end

  // State and output registers, cleared immediately by the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= HUNT;
      good_q        <= '0;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      locked_q      <= 1'b0;
      disp_q        <= 1'b0;
      x_pos_q       <= '0;
      y_pos_q       <= '0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_q        <= good_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      locked_q      <= locked_d;
      disp_q        <= disp_d;
      x_pos_q       <= x_pos_d;
      y_pos_q       <= y_pos_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign locked      = locked_q;
  assign disp        = disp_q;
  assign x_pos       = x_pos_q;
  assign y_pos       = y_pos_q;
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: drives an ideal 14x8 sync source with injected faults
// into vga_sync_decoder. Every sampled clock pushes the expected outputs into
// a queue; a monitor on the falling edge pops and compares.
module tb_vga_sync_decoder;

  localparam int H_SYNC  = 2;
  localparam int H_BACK  = 3;
  localparam int H_DISP  = 8;
  localparam int H_FRONT = 1;
  localparam int V_SYNC  = 1;
  localparam int V_BACK  = 2;
  localparam int V_DISP  = 4;
  localparam int V_FRONT = 1;
  localparam int H_LIMIT = 14;
  localparam int V_LIMIT = 8;
  localparam int X0      = 5;
  localparam int Y0      = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vga_hs = 1'b1;
  logic       vga_vs = 1'b1;
  logic       locked, disp, frame_start, sync_err;
  logic [2:0] x_pos;
  logic [1:0] y_pos;

  typedef struct packed {
    logic       locked;
    logic       disp;
    logic [2:0] x;
    logic [1:0] y;
    logic       fs;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   fail_lines = 0;

  // Source position and fault controls
  int sx = 0;
  int sy = 5;
  int stretch_sy = -1;
  int wide_sy = -1;
  int vs_skip = 0;
  bit suppress_cur = 1'b0;

  // Expected lock tracking, hand-derived: lock follows the 3rd vs pulse
  // after a fault or reset, and drops on any injected fault while locked.
  bit exp_locked = 1'b0;
  int falls_to_lock = 3;

  vga_sync_decoder #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_DISP(H_DISP), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_DISP(V_DISP), .V_FRONT(V_FRONT),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .locked(locked),
    .disp(disp),
    .x_pos(x_pos),
    .y_pos(y_pos),
    .frame_start(frame_start),
    .sync_err(sync_err)
  );

  // Pixel clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    if (actual !== expected) begin
      miscompares++;
      if (fail_lines < 40)
        $display("[TB] FAIL %s at %0t: got %0d, expected %0d (src x=%0d y=%0d)",
                 name, $time, actual, expected, sx, sy);
      fail_lines++;
    end
  endtask

  // One source clock per iteration: drive hs/vs, queue the expected outputs.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      int   line_len;
      bit   hs, vs, vsf, fault, act;
      exp_t e;
      line_len = (sy == stretch_sy) ? 15 : H_LIMIT;
      if (sx == 0 && sy == 0) begin
        suppress_cur = (vs_skip > 0);
        if (vs_skip > 0) vs_skip--;
      end
      hs    = !(sx < ((sy == wide_sy) ? 3 : H_SYNC));
      vs    = !(sy < V_SYNC && !suppress_cur);
      vsf   = (sx == 0 && sy == 0 && !suppress_cur);
      fault = (sy == stretch_sy && sx == 14) || (sy == wide_sy && sx == 3) ||
              (sx == 0 && sy == 0 && suppress_cur);
      vga_hs = hs;
      vga_vs = vs;
      e = '0;
      if (!reset) begin
        exp_locked    = 1'b0;
        falls_to_lock = 3;
      end else begin
        e.err = fault && exp_locked;
        if (e.err) begin
          exp_locked    = 1'b0;
          falls_to_lock = 3;
        end else if (vsf && falls_to_lock > 0) begin
          falls_to_lock--;
          if (falls_to_lock == 0) exp_locked = 1'b1;
        end
        act = exp_locked && sx >= X0 && sx < X0 + H_DISP && sy >= Y0 && sy < Y0 + V_DISP;
        e.fs     = vsf;
        e.locked = exp_locked;
        e.disp   = act;
        e.x      = act ? 3'(sx - X0) : 3'd0;
        e.y      = act ? 2'(sy - Y0) : 2'd0;
      end
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      sx++;
      if (sx >= line_len) begin
        sx = 0;
        if (sy == stretch_sy) stretch_sy = -1;
        if (sy == wide_sy) wide_sy = -1;
        sy = (sy + 1) % V_LIMIT;
      end
    end
  endtask

  // Advance the source to the start of line ty, bounded.
  task automatic runTo(input int ty);
    int guard = 0;
    while (!(sx == 0 && sy == ty) && guard < 200) begin
      applyStimulus(1);
      guard++;
    end
    vectors++;
    if (guard >= 200) begin
      miscompares++;
      $display("[TB] FAIL runTo line %0d: got x=%0d y=%0d, expected x=0 y=%0d", ty, sx, sy, ty);
    end
  endtask

  // Monitor: compare each queued expectation on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      checkOutput("locked", 32'(locked), 32'(mon_e.locked));
      checkOutput("disp", 32'(disp), 32'(mon_e.disp));
      checkOutput("x_pos", 32'(x_pos), 32'(mon_e.x));
      checkOutput("y_pos", 32'(y_pos), 32'(mon_e.y));
      checkOutput("frame_start", 32'(frame_start), 32'(mon_e.fs));
      checkOutput("sync_err", 32'(sync_err), 32'(mon_e.err));
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence
  initial begin
    $display("[TB] starting vga_sync_decoder bench");
    reset = 1'b0;
    applyStimulus(4);
    reset = 1'b1;

    // Clean stream from mid-frame: lock after the 3rd vs pulse
    applyStimulus(3 * H_LIMIT + 2 * 112 + 30);

    // One line stretched to 15 clocks
    runTo(1);
    stretch_sy = 4;
    applyStimulus(4 * 112 + 20);

    // hs pulse one clock too wide
    runTo(1);
    wide_sy = 4;
    applyStimulus(4 * 112 + 20);

    // vs missing for two frames
    runTo(1);
    vs_skip = 2;
    applyStimulus(6 * 112 + 20);

    // Async reset mid-line while locked
    runTo(4);
    applyStimulus(7);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    checkOutput("reset_locked", 32'(locked), 32'd0);
    checkOutput("reset_disp", 32'(disp), 32'd0);
    checkOutput("reset_x_pos", 32'(x_pos), 32'd0);
    checkOutput("reset_y_pos", 32'(y_pos), 32'd0);
    checkOutput("reset_frame_start", 32'(frame_start), 32'd0);
    checkOutput("reset_sync_err", 32'(sync_err), 32'd0);
    applyStimulus(3);
    reset = 1'b1;
    applyStimulus(4 * 112 + 40);

    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side VGA timing recovery. Samples an incoming active-low `vga_hs`/`vga_vs` pair from the same clock domain and checks line length, frame length and sync pulse widths against the configured mode. Declares lock after a run of clean frames, then regenerates `disp`, `x_pos` and `y_pos` one clock behind the source. Sits at the input of capture, overlay and self-test logic that needs pixel coordinates from an external sync stream.

## Interface
- `H_SYNC`, default 112: hs low width, clocks
- `H_BACK`, default 248: horizontal back porch, clocks
- `H_DISP`, default 1280: active pixels per line
- `H_FRONT`, default 48: horizontal front porch, clocks
- `V_SYNC`, default 3: vs low width, lines
- `V_BACK`, default 38: vertical back porch, lines
- `V_DISP`, default 1024: active lines
- `V_FRONT`, default 1: vertical front porch, lines
- `LOCK_FRAMES`, default 2: consecutive clean frames required for lock (≥1)
- Derived: `H_LIMIT` = sum of H terms; `V_LIMIT` = sum of V terms; `x_width` = $clog2(H_DISP); `y_width` = $clog2(V_DISP)

- `clk`  in  1  pixel clock
- `reset`  in  1  asynchronous, active-low
- `vga_hs`  in  1  horizontal sync, low during pulse, synchronous to clk
- `vga_vs`  in  1  vertical sync, low during pulse, synchronous to clk
- `locked`  out  1  timing verified
- `disp`  out  1  active-video pixel, registered
- `x_pos`  out  x_width  column within active area
- `y_pos`  out  y_width  row within active area
- `frame_start`  out  1  one-cycle pulse on vs falling edge
- `sync_err`  out  1  one-cycle pulse on any timing violation while checking or locked

## Operation
- Registers `hs_d`/`vs_d` hold the previous samples (reset to 1).
  - hs_fall = hs_d & ~vga_hs; hs_rise = ~hs_d & vga_hs; likewise vs_fall and vs_rise.
- `h_cnt` (width $clog2(H_LIMIT)):
  - loads 0 on hs_fall;
  - otherwise increments;
  - if it would exceed H_LIMIT-1, it wraps to 0 and raises a violation (missing hs).
- `v_cnt` (width $clog2(V_LIMIT)):
  - loads 0 on vs_fall;
  - else increments on hs_fall;
  - past V_LIMIT-1 it wraps to 0 with a violation (missing vs).
- vs_fall is expected coincident with hs_fall. vs_fall takes priority for `v_cnt`.
- Checks are evaluated before counter updates and use current values:
  - hs_fall: `h_cnt` must be H_LIMIT-1.
  - hs_rise: `h_cnt` must be H_SYNC-1.
  - vs_fall: `v_cnt` must be V_LIMIT-1, and hs_fall must be asserted the same cycle.
  - vs_rise: `v_cnt` must be V_SYNC-1.
- FSM states: HUNT, CHECK, LOCKED. `good_frames` counter has width $clog2(LOCK_FRAMES+1).
  - HUNT: violations are ignored. On vs_fall, go to CHECK with good_frames=0.
  - CHECK, any violation: `sync_err` pulses and FSM goes to HUNT.
  - CHECK, vs_fall with no violation that cycle: good_frames+1. Reaching LOCK_FRAMES goes to LOCKED.
  - LOCKED, any violation: `sync_err` pulses, FSM goes to HUNT, `locked` drops.
- The vs_fall that enters CHECK is not counted as a good frame. Only frames fully bracketed by two vs_falls inside CHECK count.
- `locked` = (state == LOCKED), registered.
- `disp` (registered) = locked next-state, and `h_cnt` in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP), and `v_cnt` in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP). Counter values are post-update.
- `x_pos` = h_cnt − H_SYNC − H_BACK, truncated to x_width. `y_pos` is the same form in v. Both are registered, and forced to 0 whenever `disp` is 0.

## Timing
- Reset values:
  - locked=0, disp=0, x_pos=0, y_pos=0, frame_start=0, sync_err=0
  - state=HUNT, h_cnt=0, v_cnt=0, good_frames=0
- Latency: once locked, `h_cnt`, `v_cnt`, `disp`, `x_pos` and `y_pos` equal the source's internal counter/position values delayed by exactly 1 clk.
- `frame_start` is asserted the cycle after the clk edge that samples vs_fall, in every state.
- `sync_err` is asserted the cycle after the violating sample. It never lasts more than 1 cycle per violation event.
- Multiple violations in one cycle produce a single pulse.
- Lock asserts on the cycle after the LOCK_FRAMES-th clean vs_fall following the entry vs_fall.
- Asynchronous reset mid-frame clears everything immediately. Re-lock needs a fresh HUNT→CHECK sequence.

## Test plan
Bench uses H=2/3/8/1 (H_LIMIT 14) and V=1/2/4/1 (V_LIMIT 8), LOCK_FRAMES=2, driven by an ideal sync source.
- Clean stream from reset -> `locked` rises 1 clk after the 3rd vs_fall. `sync_err` never asserts. `frame_start` pulses once per 112 clks.
- Locked, at source x=5 y=3 -> decoder shows disp=1, x_pos=0, y_pos=0 one clk later. At source x=12 y=6 -> x_pos=7, y_pos=3. At source x=13 -> disp=0, x_pos=0.
- Locked, one line stretched to 15 clks -> `sync_err` pulse at that hs_fall, `locked`=0 the next cycle, relock after 3 further vs_falls.
- Locked, hs low width 3 instead of 2 -> `sync_err` on hs_rise, state HUNT.
- vs held high for 2 frames -> violation when `v_cnt` passes 7, `sync_err` pulse, lock lost. No `frame_start` until vs resumes.
- reset asserted while locked mid-line -> all outputs 0 immediately. After release, lock returns only after 3 vs_falls.
